// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - load/store and fetch initiator for the Memoria data and instruction ports
module mem_port_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        Op2En,
  output logic        Op2RW,
  output logic [31:0] ReadWriteAddr,
  output logic [31:0] DataWrite,
  input  logic [31:0] Data,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic [31:0] pc,
  output logic [31:0] ReadPC,
  input  logic [31:0] Instruction,
  output logic        instr_valid,
  output logic [31:0] instr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [0:0] F_IDLE   = 1'b0;
  localparam logic [0:0] F_WAIT   = 1'b1;
  localparam logic [3:0] LAT      = 4'(MEM_LAT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op2en_q, op2en_d;
  logic        op2rw_q, op2rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [0:0]  f_state_q, f_state_d;
  logic [3:0]  f_cnt_q, f_cnt_d;
  logic [31:0] readpc_q, readpc_d;
  logic        ivalid_q, ivalid_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] req_word;
  logic        req_bad;
  logic        unused_pc_low;

  // Word index of the request and the alignment/range screen
  assign req_word      = {2'b00, req_addr[31:2]};
  assign req_bad       = (req_addr[1:0] != 2'b00) || (req_word >= 32'(DEPTH));
  assign unused_pc_low = ^pc[1:0];

  assign req_ready     = (state_q == S_IDLE) && !rst;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;
  assign Op2En         = op2en_q;
  assign Op2RW         = op2rw_q;
  assign ReadWriteAddr = addr_q;
  assign DataWrite     = wdata_q;

  assign pc_ready      = (f_state_q == F_IDLE) && !rst;
  assign ReadPC        = readpc_q;
  assign instr_valid   = ivalid_q;
  assign instr         = instr_q;

  // Data FSM next state: accept, hold the port for MEM_LAT cycles, then present the response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op2en_d = op2en_q;
    op2rw_d = op2rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            addr_d  = req_word;
            op2rw_d = req_we;
            wdata_d = req_wdata;
            op2en_d = 1'b1;
            cnt_d   = LAT;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        // The edge that takes the counter to zero ends the access
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          rdata_d = op2rw_q ? 32'h0 : Data;
          op2en_d = 1'b0;
          op2rw_d = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Data FSM registers; reset drops the memory enable immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op2en_q <= 1'b0;
      op2rw_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op2en_q <= op2en_d;
      op2rw_q <= op2rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Fetch FSM next state: PC wraps modulo DEPTH, instruction pulses once after MEM_LAT cycles
  always_comb begin
    f_state_d = f_state_q;
    f_cnt_d   = f_cnt_q;
    readpc_d  = readpc_q;
    ivalid_d  = 1'b0;
    instr_d   = instr_q;
    case (f_state_q)
      F_IDLE: begin
        if (pc_valid) begin
          readpc_d  = {2'b00, pc[31:2]} & 32'(DEPTH - 1);
          f_cnt_d   = LAT;
          f_state_d = F_WAIT;
        end
      end
      F_WAIT: begin
        f_cnt_d = f_cnt_q - 4'd1;
        if (f_cnt_q <= 4'd1) begin
          f_cnt_d   = '0;
          instr_d   = Instruction;
          ivalid_d  = 1'b1;
          f_state_d = F_IDLE;
        end
      end
      default: f_state_d = F_IDLE;
    endcase
  end

  // Fetch FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_state_q <= F_IDLE;
      f_cnt_q   <= '0;
      readpc_q  <= '0;
      ivalid_q  <= 1'b0;
      instr_q   <= '0;
    end else begin
      f_state_q <= f_state_d;
      f_cnt_q   <= f_cnt_d;
      readpc_q  <= readpc_d;
      ivalid_q  <= ivalid_d;
      instr_q   <= instr_d;
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - directed bench for mem_port_ctrl at MEM_LAT 1 and 3
module tb_mem_port_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance a: MEM_LAT=1
  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        a_Op2En, a_Op2RW, a_pc_valid, a_pc_ready, a_instr_valid;
  logic [31:0] a_ReadWriteAddr, a_DataWrite, a_Data, a_pc, a_ReadPC, a_Instruction, a_instr;
  // Instance b: MEM_LAT=3
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic        b_Op2En, b_Op2RW, b_pc_valid, b_pc_ready, b_instr_valid;
  logic [31:0] b_ReadWriteAddr, b_DataWrite, b_Data, b_pc, b_ReadPC, b_Instruction, b_instr;

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];

  // Memoria models: combinational reads, writes on the edge while enabled for write
  assign a_Data        = mem_a[a_ReadWriteAddr[9:0]];
  assign a_Instruction = mem_a[a_ReadPC[9:0]];
  assign b_Data        = mem_b[b_ReadWriteAddr[9:0]];
  assign b_Instruction = mem_b[b_ReadPC[9:0]];
  always @(posedge clk) begin
    if (a_Op2En && a_Op2RW) mem_a[a_ReadWriteAddr[9:0]] <= a_DataWrite;
    if (b_Op2En && b_Op2RW) mem_b[b_ReadWriteAddr[9:0]] <= b_DataWrite;
  end

  mem_port_ctrl #(.DEPTH(1024), .MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .Op2En(a_Op2En), .Op2RW(a_Op2RW), .ReadWriteAddr(a_ReadWriteAddr),
    .DataWrite(a_DataWrite), .Data(a_Data),
    .pc_valid(a_pc_valid), .pc_ready(a_pc_ready), .pc(a_pc), .ReadPC(a_ReadPC),
    .Instruction(a_Instruction), .instr_valid(a_instr_valid), .instr(a_instr)
  );

  mem_port_ctrl #(.DEPTH(1024), .MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .Op2En(b_Op2En), .Op2RW(b_Op2RW), .ReadWriteAddr(b_ReadWriteAddr),
    .DataWrite(b_DataWrite), .Data(b_Data),
    .pc_valid(b_pc_valid), .pc_ready(b_pc_ready), .pc(b_pc), .ReadPC(b_ReadPC),
    .Instruction(b_Instruction), .instr_valid(b_instr_valid), .instr(b_instr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[2]    = 32'hCAFEF00D;
    mem_a[1023] = 32'h0BADC0DE;
    mem_b[2]    = 32'h12345678;
    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_rsp_ready = 0;
    a_pc_valid = 0; a_pc = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 0;
    b_pc_valid = 0; b_pc = 0;

    // Reset values
    #1;
    check("rst_req_ready", a_req_ready, 0);
    check("rst_pc_ready", a_pc_ready, 0);
    check("rst_op2en", a_Op2En, 0);
    check("rst_op2rw", a_Op2RW, 0);
    check("rst_rwaddr", a_ReadWriteAddr, 0);
    check("rst_dwrite", a_DataWrite, 0);
    check("rst_readpc", a_ReadPC, 0);
    check("rst_rsp_valid", a_rsp_valid, 0);
    check("rst_rsp_err", a_rsp_err, 0);
    check("rst_rsp_rdata", a_rsp_rdata, 0);
    check("rst_instr_valid", a_instr_valid, 0);
    check("rst_instr", a_instr, 0);
    step(); step();
    rst = 0;
    #1;
    check("idle_req_ready", a_req_ready, 1);
    check("idle_pc_ready", a_pc_ready, 1);

    // Store 0xDEADBEEF to 0x10
    a_rsp_ready = 1;
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h10; a_req_wdata = 32'hDEADBEEF;
    step();
    a_req_valid = 0;
    check("st_op2en", a_Op2En, 1);
    check("st_op2rw", a_Op2RW, 1);
    check("st_addr", a_ReadWriteAddr, 4);
    check("st_dwrite", a_DataWrite, 32'hDEADBEEF);
    check("st_req_ready_busy", a_req_ready, 0);
    step();
    check("st_rsp_valid", a_rsp_valid, 1);
    check("st_rsp_err", a_rsp_err, 0);
    check("st_rsp_rdata", a_rsp_rdata, 0);
    check("st_op2en_off", a_Op2En, 0);
    check("st_op2rw_off", a_Op2RW, 0);
    step();
    check("st_rsp_done", a_rsp_valid, 0);
    check("st_req_ready_back", a_req_ready, 1);

    // Load 0x10
    a_req_valid = 1; a_req_we = 0; a_req_addr = 32'h10;
    step();
    a_req_valid = 0;
    check("ld_op2en", a_Op2En, 1);
    check("ld_op2rw", a_Op2RW, 0);
    check("ld_addr", a_ReadWriteAddr, 4);
    step();
    check("ld_rsp_valid", a_rsp_valid, 1);
    check("ld_rsp_rdata", a_rsp_rdata, 32'hDEADBEEF);
    check("ld_rsp_err", a_rsp_err, 0);
    step();

    // Backpressure: rsp_ready low for 5 cycles, request held valid
    a_rsp_ready = 0;
    a_req_valid = 1; a_req_we = 0; a_req_addr = 32'h10;
    step();
    check("bp_op2en", a_Op2En, 1);
    step();
    check("bp_rsp_valid", a_rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", a_rsp_valid, 1);
      check("bp_hold_rdata", a_rsp_rdata, 32'hDEADBEEF);
      check("bp_hold_err", a_rsp_err, 0);
      check("bp_hold_ready", a_req_ready, 0);
      check("bp_no_access", a_Op2En, 0);
    end
    a_rsp_ready = 1;
    step();
    check("bp_released_valid", a_rsp_valid, 0);
    check("bp_released_ready", a_req_ready, 1);
    step();
    a_req_valid = 0;
    check("bp_next_accept", a_Op2En, 1);
    step();
    check("bp_next_rdata", a_rsp_rdata, 32'hDEADBEEF);
    step();

    // Misaligned load 0x6
    a_req_valid = 1; a_req_we = 0; a_req_addr = 32'h6;
    step();
    a_req_valid = 0;
    check("mis_rsp_valid", a_rsp_valid, 1);
    check("mis_rsp_err", a_rsp_err, 1);
    check("mis_rsp_rdata", a_rsp_rdata, 0);
    check("mis_op2en", a_Op2En, 0);
    step();
    check("mis_done", a_rsp_valid, 0);
    check("mis_op2en2", a_Op2En, 0);

    // Out-of-range load 0x1000
    a_req_valid = 1; a_req_addr = 32'h1000;
    step();
    a_req_valid = 0;
    check("oor_rsp_valid", a_rsp_valid, 1);
    check("oor_rsp_err", a_rsp_err, 1);
    check("oor_rsp_rdata", a_rsp_rdata, 0);
    check("oor_op2en", a_Op2En, 0);
    step();

    // Last valid word 0xFFC
    a_req_valid = 1; a_req_addr = 32'hFFC;
    step();
    a_req_valid = 0;
    check("top_op2en", a_Op2En, 1);
    check("top_addr", a_ReadWriteAddr, 1023);
    step();
    check("top_rsp_err", a_rsp_err, 0);
    check("top_rsp_rdata", a_rsp_rdata, 32'h0BADC0DE);
    step();

    // MEM_LAT=3 load of word 2
    b_rsp_ready = 1;
    b_req_valid = 1; b_req_we = 0; b_req_addr = 32'h8;
    step();
    b_req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("l3_op2en_high", b_Op2En, 1);
      check("l3_no_rsp", b_rsp_valid, 0);
      check("l3_addr", b_ReadWriteAddr, 2);
      step();
    end
    check("l3_op2en_low", b_Op2En, 0);
    check("l3_rsp_valid", b_rsp_valid, 1);
    check("l3_rsp_rdata", b_rsp_rdata, 32'h12345678);
    step();
    check("l3_done", b_rsp_valid, 0);

    // Reset in the middle of an access
    b_req_valid = 1; b_req_addr = 32'h8;
    step();
    b_req_valid = 0;
    check("ra_op2en", b_Op2En, 1);
    #2 rst = 1;
    #1;
    check("ra_op2en_async", b_Op2En, 0);
    check("ra_req_ready_rst", b_req_ready, 0);
    step();
    rst = 0;
    #1;
    check("ra_req_ready_after", b_req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("ra_no_rsp", b_rsp_valid, 0);
      check("ra_op2en_idle", b_Op2En, 0);
    end

    // Fetch pc=0x8 concurrently with a store of 0x55AA to 0x20
    a_rsp_ready = 1;
    check("fe_pc_ready", a_pc_ready, 1);
    a_pc_valid = 1; a_pc = 32'h8;
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h20; a_req_wdata = 32'h000055AA;
    step();
    a_pc_valid = 0; a_req_valid = 0;
    check("fe_readpc", a_ReadPC, 2);
    check("fe_pc_busy", a_pc_ready, 0);
    check("fe_no_instr_yet", a_instr_valid, 0);
    check("fe_st_op2en", a_Op2En, 1);
    check("fe_st_op2rw", a_Op2RW, 1);
    step();
    check("fe_instr_valid", a_instr_valid, 1);
    check("fe_instr", a_instr, 32'hCAFEF00D);
    check("fe_pc_ready_back", a_pc_ready, 1);
    check("fe_st_rsp", a_rsp_valid, 1);
    check("fe_st_err", a_rsp_err, 0);
    step();
    check("fe_instr_pulse", a_instr_valid, 0);
    a_req_valid = 1; a_req_we = 0; a_req_addr = 32'h20;
    step();
    a_req_valid = 0;
    step();
    check("fe_st_readback", a_rsp_rdata, 32'h000055AA);
    step();

    // Out-of-range PC with low bits set wraps to word 2
    a_pc_valid = 1; a_pc = 32'h100B;
    step();
    a_pc_valid = 0;
    check("wr_readpc", a_ReadPC, 2);
    step();
    check("wr_instr_valid", a_instr_valid, 1);
    check("wr_instr", a_instr, 32'hCAFEF00D);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Memory-side initiator for the `Memoria` block. It accepts load/store requests from the CPU datapath over a valid/ready handshake and drives `Memoria` port 2 (`Op2En`, `Op2RW`, `ReadWriteAddr`, `DataWrite`, `Data`) with a fixed access latency. It also sequences instruction fetches on the `ReadPC`/`Instruction` port. It sits between the core's execute/fetch stages and `Memoria` and owns all timing of memory enables.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words in `Memoria`.
- `MEM_LAT`, 1: cycles each access is held on the memory port (1..15).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: data request present.
- `req_ready` out 1: controller can accept a data request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out 32: load data (0 for stores and errors).
- `rsp_err` out 1: misaligned or out-of-range request.
- `Op2En` out 1: port-2 enable to `Memoria`.
- `Op2RW` out 1: 1 = write, 0 = read.
- `ReadWriteAddr` out 32: word index to `Memoria`.
- `DataWrite` out 32: write data to `Memoria`.
- `Data` in 32: read data from `Memoria`.
- `pc_valid` in 1, `pc_ready` out 1, `pc` in 32: fetch request (byte address).
- `ReadPC` out 32: word index to `Memoria` instruction port.
- `Instruction` in 32: fetched word from `Memoria`.
- `instr_valid` out 1, `instr` out 32: fetched instruction, single-cycle pulse.

## Operation
- Data FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, check the request:
  - `req_addr[1:0]` != 0, or `req_addr[31:2]` >= `DEPTH`: error. Go to RESP with `rsp_err`=1 and `rsp_rdata`=0. No memory access.
  - Otherwise: latch `ReadWriteAddr` = `{2'b0, req_addr[31:2]}`, `Op2RW` = `req_we`, and `DataWrite` = `req_wdata`. Set `Op2En`=1, load the latency counter with `MEM_LAT`, and go to ACCESS.
- ACCESS: hold `Op2En`, `Op2RW`, `ReadWriteAddr`, and `DataWrite` stable. Decrement the counter each cycle.
  - On the edge where the counter reaches 0: sample `Data` into `rsp_rdata` (load) or clear it to 0 (store).
  - On the same edge: `Op2En`←0, `Op2RW`←0, state → RESP.
- RESP: `rsp_valid`=1 with stable `rsp_rdata`/`rsp_err` until `rsp_valid & rsp_ready`, then return to IDLE.
  - A store also yields one response (acknowledge, `rsp_err`=0).
- Fetch path is independent of the data FSM. It uses its own states (F_IDLE, F_WAIT) and counter.
  - F_IDLE: `pc_ready`=1. On `pc_valid`: `ReadPC` ← `{2'b0, pc[31:2]}` (low bits ignored), counter ← `MEM_LAT`, go to F_WAIT.
  - F_WAIT: when the counter reaches 0, register `instr` ← `Instruction`, pulse `instr_valid` for 1 cycle, return to F_IDLE.
  - An out-of-range PC wraps modulo `DEPTH`: `ReadPC` = `pc[31:2] % DEPTH`, with `DEPTH` a power of two.
- Data and fetch may be active in the same cycle. `Memoria` ports are independent, so there is no arbitration.

## Timing
- Reset (async, immediate): both FSMs go idle. `Op2En`=0, `Op2RW`=0, `ReadWriteAddr`=0, `DataWrite`=0, `ReadPC`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `instr_valid`=0, `instr`=0.
- `req_ready` and `pc_ready` are 0 while `rst` is high and 1 in their idle states.
- Reset during ACCESS: `Op2En` drops in the same instant. No response is ever produced for the aborted request.
- Valid access, accepted at edge E:
  - `Op2En`=1 from E through E+`MEM_LAT`.
  - `rsp_valid` rises at E+`MEM_LAT`.
  - Earliest next acceptance is E+`MEM_LAT`+2 when `rsp_ready` is held 1.
- Error request accepted at edge E: `rsp_valid` at E+1. `Op2En` never asserts.
- `req_ready` is 0 in ACCESS and RESP. A `req_valid` held during that time is not consumed and is accepted on return to IDLE.
- Fetch accepted at edge E: `instr_valid` high for exactly the cycle after E+`MEM_LAT`.
  - `pc_ready` returns to 1 in that same cycle.
  - Back-to-back fetches therefore issue every `MEM_LAT`+1 cycles.
- `rsp_rdata`/`rsp_err` must not change while `rsp_valid`=1 and `rsp_ready`=0.

## Test plan
- Store 0xDEADBEEF to addr 0x10, then load addr 0x10 (`MEM_LAT`=1):
  - `Op2En`/`Op2RW`=1/1 then 1/0, `ReadWriteAddr`=4.
  - Load `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Load with `rsp_ready` held 0 for 5 cycles: `rsp_valid` stays 1, data stable, `req_ready`=0 throughout. Accepts the next request 1 cycle after `rsp_ready` rises.
- Load addr 0x6 (misaligned) and addr 0x1000 with `DEPTH`=1024: `rsp_err`=1, `rsp_rdata`=0, `rsp_valid` one cycle after acceptance, `Op2En` never 1.
- `MEM_LAT`=3 load of word 2 preloaded with 0x12345678:
  - `Op2En` high exactly 3 cycles.
  - `rsp_rdata`=0x12345678 at acceptance+3.
- Assert `rst` mid-ACCESS: `Op2En`→0 asynchronously, no `rsp_valid`, `req_ready`=1 after reset release.
- Fetch pc=0x8 concurrently with a store:
  - `ReadPC`=2.
  - `instr` equals word 2, with `instr_valid` for one cycle.
  - Store completes unaffected.
